// File: rtl/pmsm_commutation_driver.sv
// Six-step commutation driver: position -> electrical sector -> phase pattern,
// gated by an edge-aligned PWM carrier, with IDLE/ALIGN/RUN/FAULT sequencing.
module pmsm_commutation_driver #(
    parameter int PWM_PERIOD    = 1000,
    parameter int POLE_PAIRS    = 30,
    parameter int ALIGN_PERIODS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        dir,
    input  logic [15:0] duty,
    input  logic [15:0] position_in,
    input  logic        fault_in,
    output logic [2:0]  V_phase,
    output logic [2:0]  sector,
    output logic        pwm_sync,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [15:0] PERIOD     = 16'(PWM_PERIOD);
    localparam logic [15:0] CNT_LAST   = 16'(PWM_PERIOD - 1);
    localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_PERIODS - 1);
    localparam logic [31:0] PP         = 32'(POLE_PAIRS);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_duty_l;
    logic [15:0] r_align_cnt;
    logic [2:0]  r_vphase;
    logic [2:0]  r_sector;
    logic        r_sync;

    state_t      w_state_n;
    logic [15:0] w_cnt_n;
    logic [15:0] w_duty_n;
    logic [15:0] w_align_n;
    logic [15:0] w_duty_sat;
    logic [15:0] w_elec;
    logic [2:0]  w_raw;
    logic [2:0]  w_sector;
    logic [2:0]  w_pattern;
    logic [2:0]  w_vphase_n;
    logic        w_pwm_on;
    logic        w_period_end;
    logic        w_active;
    logic        w_active_n;
    logic        w_sync_n;

    assign w_duty_sat   = (duty > PERIOD) ? PERIOD : duty;
    assign w_elec       = 16'(32'(position_in) * PP);
    assign w_raw        = 3'(({3'b000, w_elec} * 19'd6) >> 16);
    assign w_sector     = dir ? ((w_raw >= 3'd3) ? w_raw - 3'd3 : w_raw + 3'd3) : w_raw;
    assign w_period_end = (r_cnt == CNT_LAST);
    assign w_active     = (r_state == ALIGN) || (r_state == RUN);

    always_comb begin
        case (w_sector)
            3'd0:    w_pattern = 3'b001;
            3'd1:    w_pattern = 3'b011;
            3'd2:    w_pattern = 3'b010;
            3'd3:    w_pattern = 3'b110;
            3'd4:    w_pattern = 3'b100;
            default: w_pattern = 3'b101;
        endcase
    end

    // Fault dominates everything; leaving FAULT needs both fault and enable low.
    always_comb begin
        w_state_n = r_state;
        if (fault_in) begin
            w_state_n = FAULT;
        end else begin
            case (r_state)
                FAULT:   if (!enable) w_state_n = IDLE;
                IDLE:    if (enable) w_state_n = ALIGN;
                ALIGN: begin
                    if (!enable)
                        w_state_n = IDLE;
                    else if (w_period_end && r_align_cnt == ALIGN_LAST)
                        w_state_n = RUN;
                end
                default: if (!enable) w_state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        w_active_n = (w_state_n == ALIGN) || (w_state_n == RUN);
        w_cnt_n    = 16'd0;
        w_align_n  = r_align_cnt;
        w_duty_n   = r_duty_l;
        if (w_active_n && w_active)
            w_cnt_n = w_period_end ? 16'd0 : r_cnt + 16'd1;
        if (r_state == IDLE && w_state_n == ALIGN)
            w_align_n = 16'd0;
        else if (r_state == ALIGN && w_period_end)
            w_align_n = r_align_cnt + 16'd1;
        if (w_period_end || (r_state == IDLE && w_state_n == ALIGN))
            w_duty_n = w_duty_sat;
        w_pwm_on = (w_cnt_n < w_duty_n);
        w_sync_n = w_active_n && (w_cnt_n == 16'd0);
        case (w_state_n)
            ALIGN:   w_vphase_n = w_pwm_on ? 3'b001 : 3'b000;
            RUN:     w_vphase_n = w_pwm_on ? w_pattern : 3'b000;
            default: w_vphase_n = 3'b000;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the carrier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_duty_l    <= 16'd0;
            r_align_cnt <= 16'd0;
            r_vphase    <= 3'b000;
            r_sector    <= 3'd0;
            r_sync      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_duty_l    <= w_duty_n;
            r_align_cnt <= w_align_n;
            r_vphase    <= w_vphase_n;
            r_sector    <= w_sector;
            r_sync      <= w_sync_n;
        end
    end

    assign V_phase  = r_vphase;
    assign sector   = r_sector;
    assign pwm_sync = r_sync;
    assign state    = r_state;

endmodule

// File: tb/tb_pmsm_commutation_driver.sv
// Directed plus randomized bench for pmsm_commutation_driver, checked against
// a time-based behavioural model (elapsed cycles since ALIGN entry).
module tb_pmsm_commutation_driver;

    localparam int P  = 10;
    localparam int PP = 1;
    localparam int AP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] duty = 16'd0;
    logic [15:0] position_in = 16'd0;
    logic        fault_in = 1'b0;
    logic [2:0]  V_phase;
    logic [2:0]  sector;
    logic        pwm_sync;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Model: mode 0..3, elapsed cycles since entering ALIGN, latched duty
    int mMode = 0;
    int mT = 0;
    int mDuty = 0;
    int eV = 0;
    int eSec = 0;
    int eSync = 0;

    pmsm_commutation_driver #(
        .PWM_PERIOD(P),
        .POLE_PAIRS(PP),
        .ALIGN_PERIODS(AP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .dir(dir),
        .duty(duty),
        .position_in(position_in),
        .fault_in(fault_in),
        .V_phase(V_phase),
        .sector(sector),
        .pwm_sync(pwm_sync),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic int patternOf(int s);
        case (s)
            0: return 1;
            1: return 3;
            2: return 2;
            3: return 6;
            4: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int sectorOf(int pos, int d);
        int elec = (pos * PP) % 65536;
        int raw = (elec * 6) / 65536;
        return d ? (raw + 3) % 6 : raw;
    endfunction

    function automatic int satDuty(int d);
        return (d > P) ? P : d;
    endfunction

    task automatic modelEdge();
        int  oldMode = mMode;
        int  oldT = mT;
        int  newMode = mMode;
        bit  oldActive = (oldMode == 1) || (oldMode == 2);
        bit  newActive;
        bit  on;
        if (fault_in) newMode = 3;
        else if (oldMode == 3) begin
            if (!enable) newMode = 0;
        end
        else if (oldActive && !enable) newMode = 0;
        else if (oldMode == 0 && enable) newMode = 1;
        else if (oldMode == 1 && oldT == AP * P - 1) newMode = 2;
        newActive = (newMode == 1) || (newMode == 2);
        if (oldActive && (oldT % P) == P - 1) mDuty = satDuty(int'(duty));
        if (oldMode == 0 && newMode == 1) mDuty = satDuty(int'(duty));
        mT = (oldActive && newActive) ? oldT + 1 : 0;
        mMode = newMode;
        eSec = sectorOf(int'(position_in), int'(dir));
        on = (mT % P) < mDuty;
        if (mMode == 1) eV = on ? 1 : 0;
        else if (mMode == 2) eV = on ? patternOf(eSec) : 0;
        else eV = 0;
        eSync = (newActive && (mT % P) == 0) ? 1 : 0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (V_phase === 3'(eV)) else begin
            errors++;
            $error("[TB] FAIL %s V_phase observed=%0d expected=%0d", tag, V_phase, eV);
        end
        checks++;
        assert (sector === 3'(eSec)) else begin
            errors++;
            $error("[TB] FAIL %s sector observed=%0d expected=%0d", tag, sector, eSec);
        end
        checks++;
        assert (pwm_sync === 1'(eSync)) else begin
            errors++;
            $error("[TB] FAIL %s pwm_sync observed=%0d expected=%0d", tag, pwm_sync, eSync);
        end
        checks++;
        assert (state === 2'(mMode)) else begin
            errors++;
            $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, mMode);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic d, input logic [15:0] du,
                                 input logic [15:0] pos, input logic f, input string tag);
        enable = en;
        dir = d;
        duty = du;
        position_in = pos;
        fault_in = f;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    logic [15:0] posTab [7] = '{16'h0000, 16'h2AAA, 16'h2AAB, 16'h5556, 16'h8000, 16'hAAAB, 16'hD556};
    int secTab [7] = '{0, 0, 1, 2, 3, 4, 5};
    int patTab [7] = '{1, 1, 3, 2, 6, 4, 5};

    initial begin
        int ones;
        logic [20:0] syncMask;
        logic [20:0] syncExp;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Align timing then RUN
        ones = 0;
        syncMask = '0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 16'd4, 16'h0000, 1'b0, "align");
            if (V_phase === 3'b001) ones++;
            syncMask[i] = pwm_sync;
        end
        checkValue("align_on_cycles", ones, 8);
        applyStimulus(1'b1, 1'b0, 16'd4, 16'h0000, 1'b0, "run_entry");
        syncMask[20] = pwm_sync;
        checkValue("run_on_21st", int'(state), 2);
        syncExp = '0;
        syncExp[0] = 1'b1;
        syncExp[10] = 1'b1;
        syncExp[20] = 1'b1;
        checkValue("sync_offsets", int'(syncMask), int'(syncExp));

        // Sector sweep forward with full duty
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'd10, 16'h0000, 1'b0, "latch10");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 16'd10, posTab[i], 1'b0, "sweep");
            checkValue("sweep_sector", int'(sector), secTab[i]);
            checkValue("sweep_vphase", int'(V_phase), patTab[i]);
        end

        // Reverse direction
        applyStimulus(1'b1, 1'b1, 16'd10, 16'h0000, 1'b0, "reverse");
        checkValue("reverse_sector", int'(sector), 3);
        checkValue("reverse_vphase", int'(V_phase), 6);

        // Duty boundaries
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'd0, 16'h2AAB, 1'b0, "duty0");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h8000, 1'b0, "dutymax");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'd3, 16'h5556, 1'b0, "duty3");
        for (int i = 0; i < P && (mT % P) != 5; i++)
            applyStimulus(1'b1, 1'b0, 16'd3, 16'h5556, 1'b0, "duty3_seek");
        for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b0, 16'd7, 16'h5556, 1'b0, "duty7");

        // Fault handling
        applyStimulus(1'b1, 1'b0, 16'd7, 16'hAAAB, 1'b1, "fault_on");
        checkValue("fault_state", int'(state), 3);
        checkValue("fault_vphase", int'(V_phase), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'd7, 16'hAAAB, 1'b0, "fault_hold");
        checkValue("fault_held", int'(state), 3);
        applyStimulus(1'b0, 1'b0, 16'd7, 16'hAAAB, 1'b0, "fault_clear");
        checkValue("fault_to_idle", int'(state), 0);
        applyStimulus(1'b1, 1'b0, 16'd7, 16'hAAAB, 1'b0, "restart");
        checkValue("restart_align", int'(state), 1);
        applyStimulus(1'b0, 1'b0, 16'd7, 16'hAAAB, 1'b1, "en_fall_fault");
        applyStimulus(1'b0, 1'b0, 16'd7, 16'hAAAB, 1'b0, "to_idle");
        applyStimulus(1'b1, 1'b0, 16'd7, 16'hAAAB, 1'b1, "en_rise_fault");
        checkValue("en_rise_fault_state", int'(state), 3);
        applyStimulus(1'b0, 1'b0, 16'd7, 16'hAAAB, 1'b0, "to_idle2");

        // Async reset in RUN
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 16'd10, 16'hAAAB, 1'b0, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async_vphase", int'(V_phase), 0);
        checkValue("async_sector", int'(sector), 0);
        checkValue("async_sync", int'(pwm_sync), 0);
        checkValue("async_state", int'(state), 0);
        mMode = 0;
        mT = 0;
        mDuty = 0;
        eV = 0;
        eSec = 0;
        eSync = 0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'd5, 16'h5556, 1'b0, "post_reset");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] du;
            case ($urandom_range(0, 3))
                0:       du = 16'hFFFF;
                default: du = 16'($urandom_range(0, 12));
            endcase
            applyStimulus(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), du,
                          16'($urandom), 1'($urandom_range(0, 49) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
